// File: rtl/dphy_rx_hs_ctrl.sv
// dphy_rx_hs_ctrl
// ----------------------------------------------------------------------------
// Sequences the D-PHY RX lane for one HS burst:
//   - tracks the lane-0 LP pair through LP-11 -> LP-01 -> LP-00,
//   - times the termination enable and the HS settle interval,
//   - hunts for the 0xB8 sync byte on lane 0,
//   - forwards aligned payload bytes from all lanes, and
//   - returns to LP when a stop state (LP-11 for two cycles) is seen.
//
// Optional feature: define DPHY_RX_ERR_CNT_EN to add err_count[15:0], a
// saturating count of sync_err / lp_err pulses that only reset clears.
//
// Ports:
//   clk         byte clock from the PHY
//   reset_n     asynchronous active-low reset
//   enable      controller enable; low forces IDLE
//   lp_data0    lane-0 LP state {Dp,Dn}, asynchronous to clk
//   byte_in     HS bytes, lane 0 in [7:0]
//   term_en     termination enable to the PHY
//   hs_en       HS receiver enable to the PHY
//   byte_out    registered payload bytes
//   byte_valid  byte_out carries payload
//   sof         one-cycle pulse with the first valid byte of a burst
//   hs_active   high in SETTLE, SYNC, HS_RX
//   sync_err    one-cycle pulse on sync timeout
//   lp_err      one-cycle pulse on an illegal LP sequence
//   state       current FSM state encoding
//   err_count   (DPHY_RX_ERR_CNT_EN only) saturating error count
// ----------------------------------------------------------------------------
module dphy_rx_hs_ctrl #(
  parameter int LANES        = 4,
  parameter int TERM_DLY     = 2,
  parameter int SETTLE_CNT   = 8,
  parameter int SYNC_TIMEOUT = 32,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         lp_data0,
  input  logic [LANES*8-1:0] byte_in,
  output logic               term_en,
  output logic               hs_en,
  output logic [LANES*8-1:0] byte_out,
  output logic               byte_valid,
  output logic               sof,
  output logic               hs_active,
  output logic               sync_err,
  output logic               lp_err,
  output logic [2:0]         state
`ifdef DPHY_RX_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HS_RQST   = 3'd1,
    ST_HS_PREP   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_SYNC      = 3'd4,
    ST_HS_RX     = 3'd5,
    ST_WAIT_STOP = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TERM_LAST   = CNT_W'(TERM_DLY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CNT - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [7:0]       SYNC_BYTE   = 8'hB8;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       lp_meta_reg;
  logic [1:0]       lp_s;
  logic [1:0]       lp_s_d;
  logic             stop_ok;

  // A single LP-11 sample while HS is running can be an aliased HS level;
  // only two consecutive LP-11 samples count as a real stop state.
  assign stop_ok = (lp_s == 2'b11) && (lp_s_d == 2'b11);
  assign state   = state_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      lp_meta_reg <= 2'b11;
      lp_s        <= 2'b11;
      lp_s_d      <= 2'b11;
      term_en     <= 1'b0;
      hs_en       <= 1'b0;
      hs_active   <= 1'b0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      sof         <= 1'b0;
      sync_err    <= 1'b0;
      lp_err      <= 1'b0;
    end else begin
      lp_meta_reg <= lp_data0;
      lp_s        <= lp_meta_reg;
      lp_s_d      <= lp_s;

      // Every registered output defaults to its IDLE value; the branches
      // below re-assert whatever the next state needs.
      term_en    <= 1'b0;
      hs_en      <= 1'b0;
      hs_active  <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      sof        <= 1'b0;
      sync_err   <= 1'b0;
      lp_err     <= 1'b0;

      if (!enable) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (lp_s == 2'b01) state_reg <= ST_HS_RQST;
          end

          ST_HS_RQST: begin
            case (lp_s)
              2'b00: begin
                state_reg <= ST_HS_PREP;
                cnt_reg   <= '0;
              end
              2'b11: state_reg <= ST_IDLE;
              2'b10: begin
                state_reg <= ST_IDLE;
                lp_err    <= 1'b1;
              end
              default: ;
            endcase
          end

          ST_HS_PREP: begin
            case (lp_s)
              2'b00: begin
                if (cnt_reg == TERM_LAST) begin
                  state_reg <= ST_SETTLE;
                  cnt_reg   <= '0;
                  term_en   <= 1'b1;
                  hs_active <= 1'b1;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                end
              end
              2'b11: state_reg <= ST_IDLE;
              default: begin
                state_reg <= ST_IDLE;
                lp_err    <= 1'b1;
              end
            endcase
          end

          ST_SETTLE: begin
            if (stop_ok) begin
              state_reg <= ST_IDLE;
            end else begin
              term_en   <= 1'b1;
              hs_active <= 1'b1;
              if (cnt_reg == SETTLE_LAST) begin
                state_reg <= ST_SYNC;
                cnt_reg   <= '0;
                hs_en     <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end

          ST_SYNC: begin
            // Stop has priority over a coincident sync match.
            if (stop_ok) begin
              state_reg <= ST_IDLE;
            end else if (byte_in[7:0] == SYNC_BYTE) begin
              state_reg <= ST_HS_RX;
              term_en   <= 1'b1;
              hs_en     <= 1'b1;
              hs_active <= 1'b1;
            end else if (cnt_reg == SYNC_LAST) begin
              state_reg <= ST_WAIT_STOP;
              cnt_reg   <= '0;
              sync_err  <= 1'b1;
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              term_en   <= 1'b1;
              hs_en     <= 1'b1;
              hs_active <= 1'b1;
            end
          end

          ST_HS_RX: begin
            if (stop_ok) begin
              state_reg <= ST_IDLE;
            end else begin
              term_en    <= 1'b1;
              hs_en      <= 1'b1;
              hs_active  <= 1'b1;
              byte_out   <= byte_in;
              byte_valid <= 1'b1;
              // byte_valid is still low on the first HS_RX cycle only.
              sof        <= ~byte_valid;
            end
          end

          ST_WAIT_STOP: begin
            if (stop_ok) state_reg <= ST_IDLE;
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DPHY_RX_ERR_CNT_EN
  // Counts the registered error pulses; both in one cycle count once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if ((sync_err || lp_err) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dphy_rx_hs_ctrl.sv
// tb_dphy_rx_hs_ctrl
// ----------------------------------------------------------------------------
// Directed self-checking bench for dphy_rx_hs_ctrl (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so every expectation refers to the state after that edge.
// lp_data0 needs three edges to reach a state decision (two synchronizer
// flops plus the FSM) and a stop needs one edge more.
// ----------------------------------------------------------------------------
module tb_dphy_rx_hs_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  lp_data0 = 2'b11;
  logic [31:0] byte_in = '0;
  logic        term_en;
  logic        hs_en;
  logic [31:0] byte_out;
  logic        byte_valid;
  logic        sof;
  logic        hs_active;
  logic        sync_err;
  logic        lp_err;
  logic [2:0]  state;
`ifdef DPHY_RX_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  dphy_rx_hs_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .lp_data0   (lp_data0),
    .byte_in    (byte_in),
    .term_en    (term_en),
    .hs_en      (hs_en),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .sof        (sof),
    .hs_active  (hs_active),
    .sync_err   (sync_err),
    .lp_err     (lp_err),
    .state      (state)
`ifdef DPHY_RX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From IDLE with lane at stop: LP-01 then LP-00 into SETTLE.
  task automatic enter_settle();
    lp_data0 = 2'b01;
    step(3);
    check("rqst_state", 32'(state), 32'd1);
    lp_data0 = 2'b00;
    step(3);
    check("prep_state", 32'(state), 32'd2);
    check("prep_term", 32'(term_en), 32'd0);
    step(2);
    check("settle_state", 32'(state), 32'd3);
    check("settle_term", 32'(term_en), 32'd1);
    check("settle_hsen", 32'(hs_en), 32'd0);
    check("settle_active", 32'(hs_active), 32'd1);
  endtask

  task automatic enter_sync();
    enter_settle();
    step(7);
    check("settle_hold_hsen", 32'(hs_en), 32'd0);
    step(1);
    check("sync_state", 32'(state), 32'd4);
    check("sync_hsen", 32'(hs_en), 32'd1);
  endtask

  // Sync byte on lane 0, then HS_RX entered with nothing valid yet.
  task automatic hit_sync();
    byte_in = 32'hDEADBEB8;
    step(1);
    check("rx_state", 32'(state), 32'd5);
    check("rx_sync_not_fwd", 32'(byte_valid), 32'd0);
  endtask

  task automatic go_stop();
    lp_data0 = 2'b11;
    step(4);
  endtask

  initial begin
    // Reset state.
    step(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_term", 32'(term_en), 32'd0);
    check("rst_hsen", 32'(hs_en), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_out", byte_out, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    step(4);
    check("idle_state", 32'(state), 32'd0);

    // Normal burst with ten payload words.
    enter_sync();
    hit_sync();
    for (int i = 0; i < 10; i++) begin
      byte_in = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)};
      step(1);
      check("burst_valid", 32'(byte_valid), 32'd1);
      check("burst_data", byte_out, {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)});
      check("burst_sof", 32'(sof), (i == 0) ? 32'd1 : 32'd0);
    end
    lp_data0 = 2'b11;
    step(3);
    check("stop_pending_valid", 32'(byte_valid), 32'd1);
    step(1);
    check("stop_state", 32'(state), 32'd0);
    check("stop_term", 32'(term_en), 32'd0);
    check("stop_hsen", 32'(hs_en), 32'd0);
    check("stop_valid", 32'(byte_valid), 32'd0);
    $display("burst: 10 words, stop to IDLE");
    step(1);

    // Single-cycle LP-11 glitch is ignored, two cycles exit.
    enter_sync();
    hit_sync();
    byte_in = 32'h44332211;
    lp_data0 = 2'b11;
    step(1);
    lp_data0 = 2'b00;
    step(6);
    check("glitch_state", 32'(state), 32'd5);
    check("glitch_valid", 32'(byte_valid), 32'd1);
    check("glitch_data", byte_out, 32'h44332211);
    go_stop();
    check("glitch_exit_state", 32'(state), 32'd0);
    check("glitch_exit_valid", 32'(byte_valid), 32'd0);
    $display("glitch: 1-cycle LP-11 ignored, 2-cycle exits");
    step(1);

    // Sync timeout.
    enter_sync();
    byte_in = 32'h000000AA;
    step(31);
    check("to_pre_state", 32'(state), 32'd4);
    check("to_pre_err", 32'(sync_err), 32'd0);
    step(1);
    check("to_state", 32'(state), 32'd6);
    check("to_err", 32'(sync_err), 32'd1);
    check("to_hsen", 32'(hs_en), 32'd0);
    check("to_term", 32'(term_en), 32'd0);
    step(1);
    check("to_err_pulse", 32'(sync_err), 32'd0);
    check("to_wait", 32'(state), 32'd6);
    lp_data0 = 2'b11;
    step(3);
    check("to_wait_hold", 32'(state), 32'd6);
    step(1);
    check("to_idle", 32'(state), 32'd0);
    $display("timeout: sync_err after 32 cycles, WAIT_STOP to IDLE");
    step(1);

    // Illegal LP sequence 11 -> 01 -> 10.
    lp_data0 = 2'b01;
    step(3);
    check("ill_rqst", 32'(state), 32'd1);
    lp_data0 = 2'b10;
    step(2);
    check("ill_hold", 32'(state), 32'd1);
    step(1);
    check("ill_state", 32'(state), 32'd0);
    check("ill_err", 32'(lp_err), 32'd1);
    check("ill_term", 32'(term_en), 32'd0);
    step(1);
    check("ill_err_pulse", 32'(lp_err), 32'd0);
`ifdef DPHY_RX_ERR_CNT_EN
    check("err_count", 32'(err_count), 32'd2);
`endif
    go_stop();
    $display("illegal LP: lp_err pulse, back to IDLE");

    // Reset in the middle of a burst.
    enter_sync();
    hit_sync();
    byte_in = 32'h12345678;
    step(2);
    check("mid_valid_before", 32'(byte_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_valid", 32'(byte_valid), 32'd0);
    check("mid_rst_term", 32'(term_en), 32'd0);
    check("mid_rst_hsen", 32'(hs_en), 32'd0);
    check("mid_rst_out", byte_out, 32'd0);
    lp_data0 = 2'b11;
    step(2);
    reset_n = 1'b1;
    step(4);
    enter_sync();
    hit_sync();
    byte_in = 32'hCAFE0042;
    step(1);
    check("post_rst_data", byte_out, 32'hCAFE0042);
    check("post_rst_sof", 32'(sof), 32'd1);
    go_stop();
    $display("reset mid-burst: outputs cleared, fresh burst received");
    step(1);

    // enable drop while settling.
    enter_settle();
    enable = 1'b0;
    step(1);
    check("en_state", 32'(state), 32'd0);
    check("en_term", 32'(term_en), 32'd0);
    check("en_active", 32'(hs_active), 32'd0);
    check("en_lp_err", 32'(lp_err), 32'd0);
    check("en_sync_err", 32'(sync_err), 32'd0);
    enable = 1'b1;
    go_stop();
    check("en_idle", 32'(state), 32'd0);
    $display("enable drop: IDLE without error pulse");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dphy_rx_hs_ctrl.md
Name: dphy_rx_hs_ctrl

Overview:
Sequences the D-PHY RX lane for one HS burst. Tracks the lane-0 LP state pair through the entry sequence (LP-11 -> LP-01 -> LP-00), times termination enable and HS settle, then hunts for the 0xB8 sync byte. Forwards aligned payload bytes from all lanes with valid/start markers and returns the PHY to LP on the stop state. Sits between the DPHY_RX_TOP byte/LP outputs and the CSI-2 packet parser, driving DPHY_RX_TOP term_en and hs_en.

Parameters:
LANES, 4, number of HS data lanes
TERM_DLY, 2, clk cycles in LP-00 before term_en asserts (min 1)
SETTLE_CNT, 8, clk cycles with term_en high before hs_en asserts (min 1)
SYNC_TIMEOUT, 32, max clk cycles in SYNC without sync byte
CNT_W, 8, width of internal delay counter; must hold max(TERM_DLY, SETTLE_CNT, SYNC_TIMEOUT)

Ports:
clk  in  1  byte clock (clk_byte_out of PHY)
reset_n  in  1  asynchronous active-low reset
enable  in  1  controller enable; low forces IDLE
lp_data0  in  2  lane-0 LP state {Dp,Dn}, asynchronous to clk
byte_in  in  LANES*8  HS bytes, lane 0 in [7:0]
term_en  out  1  termination enable to PHY
hs_en  out  1  HS receiver enable to PHY
byte_out  out  LANES*8  registered payload bytes
byte_valid  out  1  byte_out carries payload
sof  out  1  one-cycle pulse with first valid byte of a burst
hs_active  out  1  high in SETTLE, SYNC, HS_RX
sync_err  out  1  one-cycle pulse on sync timeout
lp_err  out  1  one-cycle pulse on illegal LP sequence
state  out  3  current FSM state encoding

Behaviour:
- Reset: all outputs 0, state IDLE (0), counters 0.
- lp_data0 passes through a 2-flop synchronizer; all decisions below use the synced value lp_s. Stop detection requires lp_s==11 for 2 consecutive cycles (stop_ok).
- States / encoding: IDLE=0, HS_RQST=1, HS_PREP=2, SETTLE=3, SYNC=4, HS_RX=5, WAIT_STOP=6.
- IDLE: lp_s==01 and enable -> HS_RQST.
- HS_RQST: 00 -> HS_PREP (counter cleared); 11 -> IDLE; 10 -> IDLE + lp_err.
- HS_PREP: counts while lp_s==00; counter reaching TERM_DLY-1 -> SETTLE (term_en=1 from the entry edge); 01/10 -> IDLE + lp_err; 11 -> IDLE.
- SETTLE: term_en=1; after SETTLE_CNT cycles -> SYNC (hs_en=1 from the entry edge).
- SYNC: term_en=hs_en=1; byte_in[7:0]==8'hB8 -> HS_RX. Sync byte is not forwarded. SYNC_TIMEOUT cycles without a match -> WAIT_STOP + sync_err.
- HS_RX: byte_out<=byte_in every cycle; byte_valid=1 starting the cycle after the sync-byte cycle (1-cycle latency). sof is high with the first valid only.
- WAIT_STOP: term_en=hs_en=0; stop_ok -> IDLE.
- Any state from SETTLE onward: stop_ok -> IDLE on the next edge. term_en, hs_en and byte_valid drop on that same edge. LP 01/10 are ignored there because HS drive aliases LP.
- enable low in any state -> IDLE next edge, outputs as IDLE. No error pulses.
- Errors are one cycle wide. Simultaneous stop_ok and sync match in SYNC: stop wins.
- Counter never wraps; it saturates at its terminal value.

Optional Feature:
DPHY_RX_ERR_CNT_EN: adds output err_count[15:0].
- Increments on each sync_err or lp_err pulse and saturates at 16'hFFFF.
- Cleared only by reset.
- If both pulses occur in one cycle, it increments by 1.
- Without the macro, no port and no counter logic.

Test Plan:
- Normal burst: LP 11->01->00 (TERM_DLY=2, SETTLE_CNT=8), byte_in lane0 0xB8 then 0x00..0x09 -> term_en 2 cycles after LP-00 seen; hs_en 8 cycles later; sof+byte_valid with byte_out lane0=0x00; 10 valid bytes; LP 11 for 2 cycles -> all low, state=0.
- Sync timeout: full entry, lane0 never 0xB8 -> sync_err pulse exactly 32 cycles after SYNC entry; hs_en=0; stays state 6 until LP-11 -> IDLE.
- Illegal LP: 11->01->10 -> lp_err pulse, state 0, term_en never asserted.
- Glitch: single-cycle LP-11 during HS_RX -> no exit, byte_valid stays 1. Two cycles of LP-11 -> exit.
- Reset mid-burst: reset_n low in HS_RX -> all outputs 0 immediately, state 0. Fresh entry sequence works afterwards.
- enable drop in SETTLE -> IDLE next edge, no error pulse. With DPHY_RX_ERR_CNT_EN: one timeout plus one illegal LP -> err_count=2.
